mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Parametrised N-requestor round-robin arbiter that serialises cache-miss/write-back traffic from multiple cores' caches onto one shared memory port. It is the multi-channel successor to the single-request arbiter between the cache and memory. It latches the winning request and drives a single-outstanding memory handshake. It returns read data with a per-requestor completion pulse and aborts stalled transfers with a timeout error.

## Interface

**Parameters**
- N_REQ, 4, number of requestors (≥2)
- ADDR_W, 12, address width
- DATA_W, 8, data width
- TIMEOUT, 15, maximum BUSY cycles waiting for mem_ack (≥1)

**Ports**
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requestor request, level, held until its done
- rw  in  N_REQ  per-requestor direction, 1 = write, 0 = read
- addr  in  N_REQ*ADDR_W  packed addresses, requestor i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  packed write data, same packing
- gnt  out  N_REQ  one-hot grant, held for the whole transfer
- done  out  N_REQ  one-cycle completion pulse to the granted requestor
- err  out  1  one-cycle pulse with done on timeout
- rdata  out  DATA_W  read data, valid when done pulses
- mem_req  out  1  memory request, level
- mem_rw  out  1  latched direction
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ack  in  1  memory completion, sampled on clk
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- busy  out  1  high in BUSY and DONE

## Operation

- **FSM states:** IDLE, BUSY, DONE.
- **Reset (rst low):** state = IDLE. gnt, done, err, mem_req, mem_rw, mem_addr, mem_wdata, rdata, busy all 0. Pointer last = N_REQ-1, so requestor 0 has first priority.
- **IDLE, any req high:**
  - Winner is the first requestor with req high, scanning last+1, last+2, … modulo N_REQ.
  - At that edge: go to BUSY, gnt[winner] = 1, last = winner, mem_req = 1.
  - Latch mem_rw, mem_addr and mem_wdata from the winner's slice.
  - Clear the timeout counter.
- **IDLE, no req:** stay in IDLE, all outputs held at 0.
- **BUSY:**
  - mem_* outputs are stable, and later input changes are ignored.
  - The counter increments each cycle mem_ack is low.
  - mem_ack high: go to DONE. rdata = mem_rdata if mem_rw = 0, otherwise rdata is unchanged. err = 0.
  - Counter reaches TIMEOUT with mem_ack still low: go to DONE, err = 1, rdata = 0.
  - Dropping req[winner] during BUSY does not abort the transfer.
- **DONE (exactly one cycle):**
  - gnt = 0, mem_req = 0, done[winner] = 1.
  - err is valid. Next state is IDLE unconditionally.
- A requestor that holds req after its done is re-arbitrated normally. The rotated pointer gives the other requestors priority first.
- The counter width is $clog2(TIMEOUT+1). It saturates, with no wrap.
- mem_ack arriving in IDLE or DONE is ignored.

## Timing

- Arbitration latency: req rises before edge k, so gnt and mem_req are high after edge k (1 cycle).
- Ack to done: mem_ack sampled high at edge m gives done/rdata after edge m, and mem_req is low after edge m.
- Back-to-back: the minimum period per transfer is 3 cycles (BUSY with immediate ack, DONE, IDLE), so the next grant comes 2 edges after done.
- Ack and timeout on the same edge: ack wins, err = 0.
- Timeout: with no ack, done and err assert after BUSY edge TIMEOUT.
- Async reset mid-BUSY: outputs clear immediately. The memory side must tolerate mem_req dropping without ack. The pointer returns to N_REQ-1.
- gnt is always one-hot or zero. done is asserted only for the requestor that held gnt in the preceding cycle.

## Test plan

- **Single read:** after reset, req = 0001, rw[0] = 0, addr0 = 0x123, mem_ack one cycle after mem_req with mem_rdata = 0xA5. Expect gnt = 0001, mem_addr = 0x123, done = 0001 and rdata = 0xA5, err = 0.
- **Round-robin fairness:** req = 1111 held continuously, each mem_ack immediate. Expect grant order 0, 1, 2, 3, 0, with a 3-cycle period.
- **Write latching:** requestor 2 writes addr 0xFFF / wdata 0x3C, then changes addr2 during BUSY. Expect mem_addr to stay 0xFFF, mem_wdata 0x3C, mem_rw = 1, and rdata unchanged.
- **Timeout:** mem_ack never asserted, TIMEOUT = 15. Expect done and err pulse after 15 BUSY cycles, rdata = 0, then the next requestor is granted.
- **Ack at the timeout edge:** mem_ack on the 15th BUSY cycle. Expect err = 0 and rdata = mem_rdata.
- **Async reset mid-transfer:** rst low during BUSY for requestor 1. Expect gnt = 0 and mem_req = 0 immediately. After release, req = 0011 gives requestor 0 first.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_rr_arbiter
// Purpose  : N-requestor round-robin arbiter onto one single-outstanding
//            memory port, with per-requestor done pulse and ack timeout.
// Revision : 1.0
// ============================================================================
module mem_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          rw,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_req,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int c_idx_w = $clog2(N_REQ);
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(N_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(TIMEOUT);
    localparam logic [N_REQ-1:0]   c_one      = N_REQ'(1);

    logic [1:0]          r_state;
    logic [c_idx_w-1:0]  r_last;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mem_req;
    logic                r_mem_rw;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [ADDR_W-1:0]   w_addr_arr  [N_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [N_REQ];
    logic                w_found;
    logic [c_idx_w-1:0]  w_win;
    logic [c_idx_w-1:0]  w_idx;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    // Scan starts just past the last winner so every requestor gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = c_idx_w'((int'(r_last) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_idle;
            r_last      <= c_last_rst;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_done <= '0;
                    r_err  <= 1'b0;
                    if (w_found) begin
                        r_state     <= c_busy;
                        r_gnt       <= c_one << w_win;
                        r_last      <= w_win;
                        r_mem_req   <= 1'b1;
                        r_mem_rw    <= rw[w_win];
                        r_mem_addr  <= w_addr_arr[w_win];
                        r_mem_wdata <= w_wdata_arr[w_win];
                        r_cnt       <= '0;
                    end
                end
                c_busy: begin
                    if (!mem_ack && r_cnt != c_cnt_sat) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                    // An ack on the timeout edge still completes normally.
                    if (mem_ack) begin
                        r_state   <= c_done;
                        r_gnt     <= '0;
                        r_mem_req <= 1'b0;
                        r_done    <= r_gnt;
                        r_err     <= 1'b0;
                        if (!r_mem_rw) begin
                            r_rdata <= mem_rdata;
                        end
                    end else if (r_cnt == c_cnt_last) begin
                        r_state   <= c_done;
                        r_gnt     <= '0;
                        r_mem_req <= 1'b0;
                        r_done    <= r_gnt;
                        r_err     <= 1'b1;
                        r_rdata   <= '0;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                    r_done  <= '0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state   <= c_idle;
                    r_gnt     <= '0;
                    r_done    <= '0;
                    r_err     <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_req   = r_mem_req;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != c_idle);

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_rr_arbiter
// Purpose  : Self-checking bench for mem_rr_arbiter (vector table, directed
//            corner sequences, randomized transactions vs. reference model).
// Revision : 1.0
// ============================================================================
module tb_mem_rr_arbiter;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        rw;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic                    err;
    logic [DATA_W-1:0]       rdata;
    logic                    mem_req;
    logic                    mem_rw;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_ack;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    busy;

    mem_rr_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_req  (mem_req),
        .mem_rw   (mem_rw),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N_REQ-1:0]  req;
        logic [N_REQ-1:0]  rw;
        int                delay;
        logic [DATA_W-1:0] mrd;
        logic [N_REQ-1:0]  exp_gnt;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
        logic              exp_rw;
        logic              exp_err;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    localparam logic [N_REQ*ADDR_W-1:0] c_base_addr  = {12'h0AB, 12'hFFF, 12'h456, 12'h123};
    localparam logic [N_REQ*DATA_W-1:0] c_base_wdata = {8'h44, 8'h3C, 8'h22, 8'h11};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        req     = '0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // delay = ack-low BUSY cycles before ack; delay >= TIMEOUT means no ack at all.
    task automatic run_xfer(input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] rwv,
                            input logic [N_REQ*ADDR_W-1:0] av, input logic [N_REQ*DATA_W-1:0] wv,
                            input int delay, input logic [DATA_W-1:0] mrd,
                            input logic [N_REQ-1:0] eg, input logic [ADDR_W-1:0] ea,
                            input logic [DATA_W-1:0] ew, input logic erw,
                            input logic eerr, input logic [DATA_W-1:0] erd);
        int waited;
        int nb;
        req     = rq;
        rw      = rwv;
        addr    = av;
        wdata   = wv;
        mem_ack = 1'b0;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (gnt == '0 && waited < 20);
        check("arb_latency", waited, 1);
        if (gnt == '0) begin
            req = '0;
            return;
        end
        check("gnt", gnt, eg);
        check("mem_req_on", {mem_req, busy, done}, {1'b1, 1'b1, 4'b0});
        check("mem_addr", mem_addr, ea);
        check("mem_wdata", mem_wdata, ew);
        check("mem_rw", mem_rw, erw);
        // Requestor-side inputs change mid-transfer and must be ignored.
        addr  = ~av;
        wdata = ~wv;
        rw    = ~rwv;
        nb = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
        for (int c = 1; c <= nb; c++) begin
            mem_ack   = (c == delay + 1);
            mem_rdata = mem_ack ? mrd : DATA_W'($urandom);
            @(negedge clk);
            if (c < nb)
                check("busy_hold", {done, mem_req, mem_addr, mem_wdata},
                      {4'b0, 1'b1, ea, ew});
        end
        mem_ack = 1'b0;
        req     = '0;
        check("done", done, eg);
        check("err", err, eerr);
        check("rdata", rdata, erd);
        check("release", {gnt, mem_req, busy}, {4'b0, 1'b0, 1'b1});
        @(negedge clk);
        check("done_clear", {done, err, gnt, busy}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int                      m_last;
        logic [DATA_W-1:0]       m_rdata;
        logic [N_REQ-1:0]        rq;
        logic [N_REQ-1:0]        rwv;
        logic [63:0]             rnd64;
        logic [N_REQ*ADDR_W-1:0] av;
        logic [N_REQ*DATA_W-1:0] wv;
        logic [DATA_W-1:0]       mrd;
        logic [DATA_W-1:0]       erd;
        int                      delay;
        int                      win;
        int                      r;
        logic                    eerr;

        vecs[0] = '{4'b0001, 4'b0000, 0,  8'hA5, 4'b0001, 12'h123, 8'h11, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{4'b0100, 4'b0100, 2,  8'h77, 4'b0100, 12'hFFF, 8'h3C, 1'b1, 1'b0, 8'hA5};
        vecs[2] = '{4'b1000, 4'b0000, 15, 8'h99, 4'b1000, 12'h0AB, 8'h44, 1'b0, 1'b1, 8'h00};
        vecs[3] = '{4'b1111, 4'b0000, 14, 8'h5A, 4'b0001, 12'h123, 8'h11, 1'b0, 1'b0, 8'h5A};
        vecs[4] = '{4'b1001, 4'b0000, 1,  8'h03, 4'b1000, 12'h0AB, 8'h44, 1'b0, 1'b0, 8'h03};
        vecs[5] = '{4'b1001, 4'b0000, 0,  8'hC4, 4'b0001, 12'h123, 8'h11, 1'b0, 1'b0, 8'hC4};
        vecs[6] = '{4'b0110, 4'b1111, 5,  8'hEE, 4'b0010, 12'h456, 8'h22, 1'b1, 1'b0, 8'hC4};
        vecs[7] = '{4'b0011, 4'b0000, 18, 8'h00, 4'b0001, 12'h123, 8'h11, 1'b0, 1'b1, 8'h00};

        rst = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {gnt, done, err, rdata, mem_req, mem_rw, mem_addr, mem_wdata, busy}, '0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", {gnt, done, err, mem_req, busy}, '0);

        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].req, vecs[v].rw, c_base_addr, c_base_wdata, vecs[v].delay,
                     vecs[v].mrd, vecs[v].exp_gnt, vecs[v].exp_addr, vecs[v].exp_wdata,
                     vecs[v].exp_rw, vecs[v].exp_err, vecs[v].exp_rdata);
        end

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_last  = N_REQ - 1;
        m_rdata = '0;
        for (int t = 0; t < 40; t++) begin
            rq    = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            rwv   = N_REQ'($urandom);
            rnd64 = {$urandom, $urandom};
            av    = rnd64[N_REQ*ADDR_W-1:0];
            wv    = N_REQ*DATA_W'($urandom);
            mrd   = DATA_W'($urandom);
            r     = $urandom_range(0, 9);
            if (r < 6)      delay = $urandom_range(0, 3);
            else if (r < 8) delay = $urandom_range(4, TIMEOUT - 1);
            else            delay = TIMEOUT + $urandom_range(0, 2);
            win = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                if (win < 0 && rq[(m_last + k) % N_REQ]) win = (m_last + k) % N_REQ;
            end
            m_last = win;
            eerr   = (delay >= TIMEOUT);
            if (eerr)          erd = '0;
            else if (rwv[win]) erd = m_rdata;
            else               erd = mrd;
            m_rdata = erd;
            run_xfer(rq, rwv, av, wv, delay, mrd, N_REQ'(1) << win,
                     av[win*ADDR_W +: ADDR_W], wv[win*DATA_W +: DATA_W], rwv[win],
                     eerr, erd);
        end

        // All requestors held, ack held high: strict rotation every 3 cycles.
        do_reset();
        req = '1; rw = '0; addr = c_base_addr; wdata = c_base_wdata;
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            win = ((i - 1) / 3) % N_REQ;
            check("rr_gnt", gnt, (i % 3 == 1) ? (N_REQ'(1) << win) : '0);
            check("rr_done", done, (i % 3 == 2) ? (N_REQ'(1) << win) : '0);
            if (i % 3 == 2) check("rr_rdata", rdata, 8'h5A);
        end
        mem_ack = 1'b0;
        req     = '0;
        @(negedge clk);

        // Asynchronous reset in the middle of a transfer.
        do_reset();
        req = 4'b0010; rw = '0;
        @(negedge clk);
        check("ar_gnt", gnt, 4'b0010);
        #2 rst = 1'b0;
        #1 check("ar_clear", {gnt, mem_req, busy}, '0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0011;
        @(negedge clk);
        check("ar_ptr", gnt, 4'b0001);
        mem_ack = 1'b1; mem_rdata = 8'h3E;
        @(negedge clk);
        mem_ack = 1'b0;
        req     = '0;
        check("ar_done", {done, err, rdata}, {4'b0001, 1'b0, 8'h3E});
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
